// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the multiply/divide sequencer: the execute-stage op selector
// and a helper that tells iterative ops apart from the HI/LO move ops.
package muldiv_sequencer_pkg;

  localparam int unsigned MD_W = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op;

  function automatic logic is_muldiv(input muldiv_op op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared datapath: right-shifting shift-add for
// multiply, left-shifting restoring subtract for divide, on unsigned magnitudes.
module muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic         is_div,
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] sreg_i,
  input  logic [W-1:0] opnd_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] sreg_o
);

  logic [W:0]   sum;
  logic [W+1:0] shifted;
  logic [W+1:0] diff;
  logic         borrow;

  always_comb begin
    // Multiply: acc holds the upper partial product, sreg the multiplier/low product.
    sum     = acc_i + (sreg_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: acc is the partial remainder, sreg the dividend/quotient.
    shifted = {acc_i, sreg_i[W-1]};
    diff    = shifted - {2'b00, opnd_i};
    borrow  = diff[W+1];
    if (is_div) begin
      acc_o  = borrow ? shifted[W:0] : diff[W:0];
      sreg_o = {sreg_i[W-2:0], ~borrow};
    end else begin
      acc_o  = {1'b0, sum[W:1]};
      sreg_o = {sum[0], sreg_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO; W steps in RUN, a sign
// fixup/writeback cycle in FIXUP, and MTHI/MTLO handled directly from IDLE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  muldiv_op     op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic         flush,
  input  logic         read_hilo,
  output logic         busy,
  output logic         stall,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W:0]      acc_q, acc_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    rs_q, rs_d;
  logic            div_q, div_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            dz_q, dz_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic [W:0]      acc_step;
  logic [W-1:0]    sreg_step;
  logic            op_signed, op_div;
  logic [W-1:0]    rs_mag, rt_mag;
  logic [2*W-1:0]  prod, prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  muldiv_step #(.W(W)) u_step (
    .is_div (div_q),
    .acc_i  (acc_q),
    .sreg_i (sreg_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step),
    .sreg_o (sreg_step)
  );

  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    rs_mag    = (op_signed && rs[W-1]) ? -rs : rs;
    rt_mag    = (op_signed && rt[W-1]) ? -rt : rt;
    prod      = {acc_q[W-1:0], sreg_q};
    prod_fix  = negq_q ? -prod : prod;
    quo_fix   = negq_q ? -sreg_q : sreg_q;
    rem_fix   = negr_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    sreg_d  = sreg_q;
    opnd_d  = opnd_q;
    rs_d    = rs_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (is_muldiv(op)) begin
            state_d = S_RUN;
            count_d = '0;
            acc_d   = '0;
            div_d   = op_div;
            rs_d    = rs;
            negq_d  = op_signed && (rs[W-1] ^ rt[W-1]);
            negr_d  = (op == MD_DIV) && rs[W-1];
            dz_d    = op_div && (rt == '0);
            // Divide iterates over the dividend; multiply over the multiplier (rt).
            sreg_d  = op_div ? rs_mag : rt_mag;
            opnd_d  = op_div ? rt_mag : rs_mag;
          end else if (op == MD_MTHI) begin
            hi_d = rs;
          end else if (op == MD_MTLO) begin
            lo_d = rs;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d  = acc_step;
          sreg_d = sreg_step;
          if (count_q == CW'(W - 1)) begin
            state_d = S_FIXUP;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!flush) begin
          done = 1'b1;
          if (!div_q) begin
            hi_d = prod_fix[2*W-1:W];
            lo_d = prod_fix[W-1:0];
          end else if (dz_q) begin
            hi_d = rs_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      sreg_q  <= '0;
      opnd_q  <= '0;
      rs_q    <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sreg_q  <= sreg_d;
      opnd_q  <= opnd_d;
      rs_q    <= rs_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = read_hilo && (busy || (start && is_muldiv(op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  muldiv_op     op;
  logic [W-1:0] rs, rt;
  logic         flush;
  logic         read_hilo;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo;

  muldiv_sequencer #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .flush     (flush),
    .read_hilo (read_hilo),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input muldiv_op o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ph,
                                             input logic [31:0] pl);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MD_MULT:  begin p = 64'(sa * sb); return p; end
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MD_MTHI: return {a, pl};
      MD_MTLO: return {ph, a};
      default: return {ph, pl};
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic reset_dut();
    reset = 1'b1; start = 1'b0; flush = 1'b0; read_hilo = 1'b0;
    op = MD_MULT; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input muldiv_op o, input logic [31:0] a, input logic [31:0] b,
                        input logic rd);
    int cyc, busy_n, stall_n, done_at;
    logic [63:0] e;
    logic md;
    md = (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
    start = 1'b1; op = o; rs = a; rt = b; read_hilo = rd;
    exp_q.push_back(ref_result(o, a, b, m_hi, m_lo));
    @(negedge clk);
    check_eq("stall_issue", 64'(stall), 64'(rd && md));
    @(posedge clk);
    #1 start = 1'b0; rs = $urandom; rt = $urandom;
    if (md) begin
      cyc = 0; busy_n = 0; stall_n = 0; done_at = 0;
      while (done_at == 0 && cyc < W + 8) begin
        @(negedge clk);
        cyc++;
        if (busy) busy_n++;
        if (stall) stall_n++;
        if (done) done_at = cyc;
      end
      check_eq("done_cycle", 64'(done_at), 64'(W + 1));
      check_eq("busy_cycles", 64'(busy_n), 64'(W + 1));
      check_eq("stall_cycles", 64'(stall_n), rd ? 64'(W + 1) : 64'd0);
      @(posedge clk);
      #1;
      check_eq("busy_after", 64'(busy), 64'd0);
      check_eq("stall_after", 64'(stall), 64'd0);
    end else begin
      @(negedge clk);
      check_eq("mt_busy", 64'(busy), 64'd0);
      check_eq("mt_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
    end
    read_hilo = 1'b0;
    e = exp_q.pop_front();
    check_eq("hilo", {hi, lo}, e);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  // Flush arrives in RUN/FIXUP cycle k after the start cycle (k = W+1 is FIXUP).
  task automatic flush_op(input muldiv_op o, input logic [31:0] a, input logic [31:0] b,
                          input int k);
    int dn;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (k - 1) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("flush_no_done", 64'(dn), 64'd0);
    check_eq("flush_hilo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dn;
    muldiv_op ro;
    reset_dut();
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check_eq("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
    check_eq("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    check_eq("div_zero_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    check_eq("mthi", 64'(hi), 64'h1234_5678);
    run_op(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b1);

    flush_op(MD_MULT, 32'd3, 32'd9, 10);
    flush_op(MD_DIV, 32'd100, 32'd7, W + 1);

    run_op(MD_DIVU, 32'd1000, 32'd7, 1'b1);
    read_hilo = 1'b1;
    @(negedge clk);
    check_eq("stall_idle", 64'(stall), 64'd0);
    @(posedge clk);
    #1 read_hilo = 1'b0;

    start = 1'b1; op = MD_MULT; rs = 32'd5; rt = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check_eq("midrst_hilo", {hi, lo}, 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("midrst_no_done", 64'(dn), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      ro = muldiv_op'($urandom_range(0, 5));
      run_op(ro, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
